// File: rtl/ochiba_loader_pkg.sv
// Shared constants and state encodings for the UART boot loader.
// Latency: n/a (declarations only).
// Backpressure: n/a; the serial line cannot be stalled, so the loader never pushes back.
package ochiba_loader_pkg;

    // First byte of every image; also the only byte that leaves P_HDR/P_ERR
    localparam logic [7:0] LOADER_HDR = 8'hA5;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        P_HDR,
        P_LEN0,
        P_LEN1,
        P_DATA,
        P_SUM,
        P_DONE,
        P_ERR
    } p_state_t;

endpackage

// File: rtl/ochiba_uart_loader_if.sv
// Instruction-RAM write port driven by the loader.
// Latency: n/a (wires only).
// Backpressure: none; the RAM must accept a write on every strobe.
interface ochiba_uart_loader_if;
    logic [31:0] instr_wdata;
    logic [31:0] instr_waddr;
    logic        instr_we;

    modport master (output instr_wdata, output instr_waddr, output instr_we);
    modport slave  (input  instr_wdata, input  instr_waddr, input  instr_we);
endinterface

// File: rtl/ochiba_uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, one-cycle byte/frame-error pulses.
// Latency: pulse fires 2 sync cycles + mid-stop-bit after the start edge on the pin.
// Backpressure: none; each byte is presented for exactly one cycle and must be consumed.
module ochiba_uart_rx
    import ochiba_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       inclk,
    input  logic       inrst,
    input  logic       rxd_i,
    output logic [7:0] rx_byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;

    rx_state_t        state_q, state_d;
    logic             sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shreg_q;
    logic             fall;
    logic             tick;

    // Synchroniser plus one extra stage for falling-edge detection; idle line is high
    always_ff @(posedge inclk or negedge inrst) begin
        if (!inrst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fall = prev_q & ~sync2_q;

    // Sample strike: half a bit into the start bit, then one full bit per data/stop bit
    always_comb begin
        tick = 1'b0;
        case (state_q)
            R_START:        tick = (cnt_q == CNT_W'(HALF - 1));
            R_DATA, R_STOP: tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
            default:        tick = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge inclk or negedge inrst) begin
        if (!inrst) state_q <= R_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a start bit that is high again at mid-bit is treated as a glitch
    always_comb begin
        state_d = state_q;
        case (state_q)
            R_IDLE:  if (fall) state_d = R_START;
            R_START: if (tick) state_d = sync2_q ? R_IDLE : R_DATA;
            R_DATA:  if (tick && (bit_cnt_q == 3'd7)) state_d = R_STOP;
            R_STOP:  if (tick) state_d = R_IDLE;
            default: state_d = R_IDLE;
        endcase
    end

    // Bit timer, bit counter and LSB-first shift register
    always_ff @(posedge inclk or negedge inrst) begin
        if (!inrst) begin
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else begin
            if ((state_q == R_IDLE) || tick) cnt_q <= '0;
            else                              cnt_q <= cnt_q + CNT_W'(1);
            if (state_q == R_START) bit_cnt_q <= '0;
            else if ((state_q == R_DATA) && tick) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                shreg_q   <= {sync2_q, shreg_q[7:1]};
            end
        end
    end

    // Stop-bit verdict: good stop delivers the byte, bad stop reports a framing error
    always_comb begin
        rx_byte_o    = shreg_q;
        byte_valid_o = (state_q == R_STOP) && tick &&  sync2_q;
        frame_err_o  = (state_q == R_STOP) && tick && !sync2_q;
    end

endmodule

// File: rtl/ochiba_uart_loader.sv
// UART boot loader: header/length/data/checksum protocol, writes words to instr_ram, gates core reset.
// Latency: write strobe one cycle after the 4th byte of a word; core released the cycle after the good checksum.
// Backpressure: none; serial bytes arrive >= 10 bit-times apart, so one write per word never collides.
module ochiba_uart_loader
    import ochiba_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH_WORDS  = 4096
) (
    input  logic                        inclk,
    input  logic                        inrst,
    input  logic                        rxd,
    input  logic                        boot_skip,
    ochiba_uart_loader_if.master        instr_if,
    output logic                        core_rst_n,
    output logic                        load_done,
    output logic                        load_err
);

    localparam int          IDX_W   = $clog2(DEPTH_WORDS) + 1;
    localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

    logic [7:0]       rx_byte;
    logic             byte_vld;
    logic             frame_err;

    p_state_t         p_state_q, p_state_d;
    logic [15:0]      len_q, len_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       csum_q, csum_d;
    logic [31:0]      word_q, word_d;
    logic [1:0]       bcnt_q, bcnt_d;
    logic             we_q, we_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      waddr_q, waddr_d;

    logic [16:0]      len_full;
    logic [IDX_W-1:0] idx_inc;
    logic             last_word;
    logic             hdr_start;

    ochiba_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .inclk        (inclk),
        .inrst        (inrst),
        .rxd_i        (rxd),
        .rx_byte_o    (rx_byte),
        .byte_valid_o (byte_vld),
        .frame_err_o  (frame_err)
    );

    assign len_full  = {1'b0, rx_byte, len_q[7:0]};
    assign idx_inc   = idx_q + IDX_W'(1);
    assign last_word = (17'(idx_inc) == {1'b0, len_q});
    assign hdr_start = byte_vld && (rx_byte == LOADER_HDR) &&
                       (((p_state_q == P_HDR) && !boot_skip) || (p_state_q == P_ERR));

    // Protocol state register
    always_ff @(posedge inclk or negedge inrst) begin
        if (!inrst) p_state_q <= P_HDR;
        else        p_state_q <= p_state_d;
    end

    // Protocol next state; framing errors only matter once a header has been accepted
    always_comb begin
        p_state_d = p_state_q;
        case (p_state_q)
            P_HDR: begin
                if (boot_skip)     p_state_d = P_DONE;
                else if (hdr_start) p_state_d = P_LEN0;
            end
            P_LEN0: begin
                if (frame_err)     p_state_d = P_ERR;
                else if (byte_vld) p_state_d = P_LEN1;
            end
            P_LEN1: begin
                if (frame_err)                  p_state_d = P_ERR;
                else if (byte_vld) begin
                    if (len_full > DEPTH_L)     p_state_d = P_ERR;
                    else if (len_full == '0)    p_state_d = P_SUM;
                    else                        p_state_d = P_DATA;
                end
            end
            P_DATA: begin
                if (frame_err) p_state_d = P_ERR;
                else if (byte_vld && (bcnt_q == 2'd3) && last_word) p_state_d = P_SUM;
            end
            P_SUM: begin
                if (frame_err)     p_state_d = P_ERR;
                else if (byte_vld) p_state_d = (rx_byte == csum_q) ? P_DONE : P_ERR;
            end
            P_DONE:  p_state_d = P_DONE;
            P_ERR:   if (hdr_start) p_state_d = P_LEN0;
            default: p_state_d = P_HDR;
        endcase
    end

    // Datapath next state: length capture, LE word assembly, running XOR, write strobe
    always_comb begin
        len_d   = len_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        word_d  = word_q;
        bcnt_d  = bcnt_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        if (hdr_start) begin
            csum_d = '0;
            idx_d  = '0;
            bcnt_d = '0;
        end else if (byte_vld) begin
            case (p_state_q)
                P_LEN0: len_d[7:0]  = rx_byte;
                P_LEN1: len_d[15:8] = rx_byte;
                P_DATA: begin
                    csum_d = csum_q ^ rx_byte;
                    word_d = {rx_byte, word_q[31:8]};
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {rx_byte, word_q[31:8]};
                        waddr_d = 32'({idx_q, 2'b00});
                        idx_d   = idx_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers; wdata/waddr hold their value between strobes
    always_ff @(posedge inclk or negedge inrst) begin
        if (!inrst) begin
            len_q   <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            word_q  <= '0;
            bcnt_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            waddr_q <= '0;
        end else begin
            len_q   <= len_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            word_q  <= word_d;
            bcnt_q  <= bcnt_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
        end
    end

    // Status outputs decode directly from the registered protocol state
    always_comb begin
        core_rst_n = (p_state_q == P_DONE);
        load_done  = (p_state_q == P_DONE);
        load_err   = (p_state_q == P_ERR);
    end

    assign instr_if.instr_we    = we_q;
    assign instr_if.instr_wdata = wdata_q;
    assign instr_if.instr_waddr = waddr_q;

endmodule

// File: tb/tb_ochiba_uart_loader.sv
// Bench for ochiba_uart_loader: serial frames in, RAM writes checked by a scoreboard monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_ochiba_uart_loader;

    localparam int CPB = 8;

    logic inclk     = 1'b0;
    logic inrst     = 1'b0;
    logic rxd       = 1'b1;
    logic boot_skip = 1'b0;
    logic core_rst_n, load_done, load_err;

    ochiba_uart_loader_if bus ();

    ochiba_uart_loader #(.CLKS_PER_BIT(CPB), .DEPTH_WORDS(4096)) u_dut (
        .inclk      (inclk),
        .inrst      (inrst),
        .rxd        (rxd),
        .boot_skip  (boot_skip),
        .instr_if   (bus),
        .core_rst_n (core_rst_n),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 inclk = ~inclk;

    int          checks = 0;
    int          passed = 0;
    int          we_cnt = 0;
    int          bv_cnt = 0;
    logic        prev_we = 1'b0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every write strobe is popped against the scoreboard
    always @(negedge inclk) begin
        logic [63:0] e;
        if (u_dut.u_rx.byte_valid_o === 1'b1) bv_cnt++;
        if (bus.instr_we === 1'b1) begin
            we_cnt++;
            check("we_one_cycle", {31'b0, prev_we}, 32'd0);
            check("write_expected", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("waddr", bus.instr_waddr, e[63:32]);
                check("wdata", bus.instr_wdata, e[31:0]);
            end
        end
        prev_we = bus.instr_we;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (CPB) @(negedge inclk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge inclk);
        end
        rxd = stop;
        repeat (CPB) @(negedge inclk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge inclk);
    endtask

    task automatic send_seq(input logic [7:0] seq[$]);
        foreach (seq[i]) send_byte(seq[i], 1'b1);
    endtask

    task automatic check_status(input string name, input logic rst_e, input logic done_e, input logic err_e);
        check({name, "_core_rst_n"}, {31'b0, core_rst_n}, {31'b0, rst_e});
        check({name, "_load_done"},  {31'b0, load_done},  {31'b0, done_e});
        check({name, "_load_err"},   {31'b0, load_err},   {31'b0, err_e});
    endtask

    task automatic do_reset();
        inrst = 1'b0;
        repeat (3) @(negedge inclk);
        check_status("in_reset", 1'b0, 1'b0, 1'b0);
        check("in_reset_we", {31'b0, bus.instr_we}, 32'd0);
        inrst = 1'b1;
        repeat (3) @(negedge inclk);
    endtask

    task automatic push_case2();
        exp_q.push_back({32'h0000_0000, 32'h1234_5678});
        exp_q.push_back({32'h0000_0004, 32'hDEAD_BEEF});
    endtask

    logic [7:0] frame_ok[$]  = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                                 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    logic [7:0] frame_bad[$] = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                                 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2B};
    logic [7:0] part4[$]     = '{8'hA5, 8'h02, 8'h00, 8'h78};
    logic [7:0] word1[$]     = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    logic [7:0] too_long[$]  = '{8'hA5, 8'h01, 8'h10};
    logic [7:0] empty_img[$] = '{8'hA5, 8'h00, 8'h00, 8'h00};

    initial begin
        int w0;
        int b0;

        // 1: reset holds everything low while the line toggles
        for (int i = 0; i < 100; i++) begin
            @(negedge inclk);
            rxd = ~rxd;
            if ((i % 25) == 24) begin
                check_status("reset_hold", 1'b0, 1'b0, 1'b0);
                check("reset_hold_we", {31'b0, bus.instr_we}, 32'd0);
            end
        end
        rxd = 1'b1;
        repeat (5) @(negedge inclk);
        check("reset_waddr", bus.instr_waddr, 32'd0);
        check("reset_wdata", bus.instr_wdata, 32'd0);
        inrst = 1'b1;
        repeat (5) @(negedge inclk);

        // 2: good two-word image
        w0 = we_cnt;
        push_case2();
        send_seq(frame_ok);
        repeat (10) @(negedge inclk);
        check("case2_we_count", 32'(we_cnt - w0), 32'd2);
        check("case2_sb_empty", 32'(exp_q.size()), 32'd0);
        check_status("case2", 1'b1, 1'b1, 1'b0);

        // 3: bad checksum, then recovery by resending a good image
        do_reset();
        w0 = we_cnt;
        push_case2();
        send_seq(frame_bad);
        repeat (10) @(negedge inclk);
        check("case3_bad_we_count", 32'(we_cnt - w0), 32'd2);
        check_status("case3_bad", 1'b0, 1'b0, 1'b1);
        w0 = we_cnt;
        push_case2();
        send_seq(frame_ok);
        repeat (10) @(negedge inclk);
        check("case3_retry_we_count", 32'(we_cnt - w0), 32'd2);
        check_status("case3_retry", 1'b1, 1'b1, 1'b0);

        // 4: framing error on 2nd data byte, then a short glitch
        do_reset();
        w0 = we_cnt;
        send_seq(part4);
        send_byte(8'h56, 1'b0);
        repeat (10) @(negedge inclk);
        check("case4_we_count", 32'(we_cnt - w0), 32'd0);
        check_status("case4_frame", 1'b0, 1'b0, 1'b1);
        b0 = bv_cnt;
        rxd = 1'b0;
        repeat (3) @(negedge inclk);
        rxd = 1'b1;
        repeat (4 * CPB) @(negedge inclk);
        check("case4_glitch_no_byte", 32'(bv_cnt - b0), 32'd0);
        check_status("case4_glitch", 1'b0, 1'b0, 1'b1);

        // 5: oversize length rejected, then an empty image accepted
        w0 = we_cnt;
        send_seq(too_long);
        repeat (10) @(negedge inclk);
        check_status("case5_long", 1'b0, 1'b0, 1'b1);
        send_seq(empty_img);
        repeat (10) @(negedge inclk);
        check("case5_we_count", 32'(we_cnt - w0), 32'd0);
        check_status("case5_empty", 1'b1, 1'b1, 1'b0);

        // 6: reset mid-load, reload from address 0, then boot_skip
        do_reset();
        w0 = we_cnt;
        exp_q.push_back({32'h0000_0000, 32'h1234_5678});
        send_seq(word1);
        check("case6_partial_we", 32'(we_cnt - w0), 32'd1);
        inrst = 1'b0;
        @(negedge inclk);
        check_status("case6_abort", 1'b0, 1'b0, 1'b0);
        check("case6_abort_waddr", bus.instr_waddr, 32'd0);
        rxd = 1'b1;
        repeat (3) @(negedge inclk);
        inrst = 1'b1;
        repeat (3) @(negedge inclk);
        w0 = we_cnt;
        push_case2();
        send_seq(frame_ok);
        repeat (10) @(negedge inclk);
        check("case6_reload_we", 32'(we_cnt - w0), 32'd2);
        check_status("case6_reload", 1'b1, 1'b1, 1'b0);

        inrst = 1'b0;
        repeat (3) @(negedge inclk);
        boot_skip = 1'b1;
        inrst = 1'b1;
        check("case6_skip_before", {31'b0, core_rst_n}, 32'd0);
        @(negedge inclk);
        check("case6_skip_core_rst_n", {31'b0, core_rst_n}, 32'd1);
        check("case6_skip_done", {31'b0, load_done}, 32'd1);
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
